perf_meas_ctrl: RTL

Synthesizable scheduler for adaptive performance-measurement windows. It runs back-to-back windows of a programmable number of clock cycles and counts accepted beats on one monitored valid/ready link. It timestamps each window against a free-running wall-clock tick input and emits one report record per window over a valid/ready port. After each window it rescales the window length so reports arrive at a steady wall-clock rate. It sits beside a switchboard queue endpoint and feeds a host-side reporter.

---
 rtl/perf_meas_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/perf_meas_ctrl.sv
// perf_meas_ctrl: runs back-to-back measurement windows of `win` clock cycles,
// counts accepted beats on one monitored valid/ready link, timestamps each
// window against a free-running wall-clock tick, and emits one report record
// per window. After every completed window the length is rescaled by
// 2**SEARCH_SHIFT so reports arrive at a roughly steady wall-clock rate.
//
// Handshake rule (report port): a record is transferred on every rising clk
// edge where rpt_valid & rpt_ready are both 1. Once rpt_valid rises, it and all
// rpt_* fields hold stable until that transfer; rpt_valid never depends
// combinationally on rpt_ready. The monitored link is observed only: a beat is
// counted on a RUN cycle where mon_valid & mon_ready are both 1.
//
// dbg_state exposes the FSM state (0=IDLE, 1=RUN, 2=REPORT) for checkers.

module perf_meas_ctrl #(
  parameter int unsigned CW             = 32,
  parameter int unsigned TW             = 32,
  parameter int unsigned DEFAULT_CYCLES = 1024,
  parameter int unsigned MIN_TICKS      = 1000,
  parameter int unsigned MAX_TICKS      = 10000,
  parameter int unsigned SEARCH_SHIFT   = 1
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          en,
  input  logic          cfg_load,
  input  logic [CW-1:0] cfg_cycles,
  input  logic [TW-1:0] time_ticks,
  input  logic          mon_valid,
  input  logic          mon_ready,
  output logic          rpt_valid,
  input  logic          rpt_ready,
  output logic [CW-1:0] rpt_cycles,
  output logic [CW-1:0] rpt_beats,
  output logic [TW-1:0] rpt_ticks,
  output logic [CW-1:0] cur_cycles,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  localparam logic [CW-1:0] WIN_RESET = CW'(DEFAULT_CYCLES);
  localparam logic [CW-1:0] WIN_ONE   = CW'(1);
  localparam logic [TW-1:0] TK_MIN    = TW'(MIN_TICKS);
  localparam logic [TW-1:0] TK_MAX    = TW'(MAX_TICKS);

  state_t        state_q, state_n;
  logic [CW-1:0] win_q, win_n;
  logic [CW-1:0] cyc_q, cyc_n;
  logic [CW-1:0] beat_q, beat_n;
  logic [TW-1:0] t0_q, t0_n;
  logic [CW-1:0] rpt_cycles_q, rpt_cycles_n;
  logic [CW-1:0] rpt_beats_q, rpt_beats_n;
  logic [TW-1:0] rpt_ticks_q, rpt_ticks_n;

  logic          beat;
  logic          start;
  logic          last_cyc;
  logic [TW-1:0] elapsed;

  // Window rescaling: grow when the window was too short in wall-clock time,
  // shrink when too long. Growth saturates to all-ones instead of wrapping;
  // shrinking never reaches zero, since zero means "disabled".
  function automatic logic [CW-1:0] adapt(input logic [CW-1:0] w,
                                          input logic [TW-1:0] t);
    logic [CW-1:0] r;
    r = w;
    if (t < TK_MIN) begin
      if ((w >> (CW - SEARCH_SHIFT)) != '0) r = '1;
      else                                  r = w << SEARCH_SHIFT;
    end else if (t > TK_MAX) begin
      if ((w >> SEARCH_SHIFT) == '0) r = WIN_ONE;
      else                           r = w >> SEARCH_SHIFT;
    end
    return r;
  endfunction

  assign beat     = mon_valid & mon_ready;
  assign elapsed  = time_ticks - t0_q;
  assign last_cyc = (cyc_q == (win_q - WIN_ONE));

  // Next-state and datapath updates; every target defaults to hold.
  always_comb begin
    state_n      = state_q;
    win_n        = win_q;
    cyc_n        = cyc_q;
    beat_n       = beat_q;
    t0_n         = t0_q;
    rpt_cycles_n = rpt_cycles_q;
    rpt_beats_n  = rpt_beats_q;
    rpt_ticks_n  = rpt_ticks_q;
    start        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cfg_load) begin
          win_n = cfg_cycles;
          if (en && (cfg_cycles != '0)) start = 1'b1;
        end else if (en && (win_q != '0)) begin
          start = 1'b1;
        end
      end

      ST_RUN: begin
        if (cfg_load) begin
          // A reload discards the running window, even on its last cycle.
          win_n = cfg_cycles;
          if (en && (cfg_cycles != '0)) start = 1'b1;
          else                          state_n = ST_IDLE;
        end else if (!en) begin
          state_n = ST_IDLE;
        end else if (last_cyc) begin
          // The beat on the final cycle belongs to this window.
          rpt_cycles_n = win_q;
          rpt_beats_n  = beat_q + CW'(beat);
          rpt_ticks_n  = elapsed;
          win_n        = adapt(win_q, elapsed);
          state_n      = ST_REPORT;
        end else begin
          cyc_n  = cyc_q + WIN_ONE;
          beat_n = beat_q + CW'(beat);
        end
      end

      ST_REPORT: begin
        // The pending record is untouched; a reload only affects the next window.
        if (cfg_load) win_n = cfg_cycles;
        if (rpt_ready) begin
          if (en && (win_n != '0)) start = 1'b1;
          else                     state_n = ST_IDLE;
        end
      end

      default: state_n = ST_IDLE;
    endcase

    // Window start: timestamp now, first counted cycle is the next one.
    if (start) begin
      state_n = ST_RUN;
      t0_n    = time_ticks;
      cyc_n   = '0;
      beat_n  = '0;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q      <= ST_IDLE;
      win_q        <= WIN_RESET;
      cyc_q        <= '0;
      beat_q       <= '0;
      t0_q         <= '0;
      rpt_cycles_q <= '0;
      rpt_beats_q  <= '0;
      rpt_ticks_q  <= '0;
    end else begin
      state_q      <= state_n;
      win_q        <= win_n;
      cyc_q        <= cyc_n;
      beat_q       <= beat_n;
      t0_q         <= t0_n;
      rpt_cycles_q <= rpt_cycles_n;
      rpt_beats_q  <= rpt_beats_n;
      rpt_ticks_q  <= rpt_ticks_n;
    end
  end

  assign rpt_valid  = (state_q == ST_REPORT);
  assign rpt_cycles = rpt_cycles_q;
  assign rpt_beats  = rpt_beats_q;
  assign rpt_ticks  = rpt_ticks_q;
  assign cur_cycles = win_q;
  assign dbg_state  = state_q;

endmodule
